// File: rtl/acc_pkg.sv
// Shared types for the banked accumulator: op codes, per-bank flag struct and widths.
package acc_pkg;

    localparam int ACC_OP_W = 3;

    typedef enum logic [ACC_OP_W-1:0] {
        ACC_NOP   = 3'd0,
        ACC_LOAD  = 3'd1,
        ACC_ADD   = 3'd2,
        ACC_SUB   = 3'd3,
        ACC_CLEAR = 3'd4,
        ACC_AND   = 3'd5,
        ACC_OR    = 3'd6,
        ACC_XOR   = 3'd7
    } acc_op_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } acc_flags_t;

    localparam acc_flags_t ACC_FLAGS_RESET = '{z: 1'b1, default: 1'b0};

endpackage

// File: rtl/acc_alu.sv
// Combinational accumulator ALU: computes the next value and flags for one bank.
// Optional clamping of ADD/SUB on signed overflow via BANKED_ACC_SATURATE_EN.
module acc_alu
    import acc_pkg::*;
#(
    parameter int DATA_LENGTH = 16
) (
    input  logic [DATA_LENGTH-1:0] acc,
    input  logic [DATA_LENGTH-1:0] in_value,
    input  logic [ACC_OP_W-1:0]    op,
    input  logic                   v_old,
    output logic [DATA_LENGTH-1:0] value,
    output logic [3:0]             flags
);

    localparam int MSB = DATA_LENGTH - 1;

`ifdef BANKED_ACC_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    acc_op_t              op_e;
    logic [DATA_LENGTH:0] sum_w;
    logic [DATA_LENGTH:0] diff_w;
    logic                 add_ovf;
    logic                 sub_ovf;
    logic [MSB:0]         sat_w;
    logic [MSB:0]         result;
    logic                 carry;
    logic                 ovf;
    acc_flags_t           new_flags;

    always_comb begin
        op_e    = acc_op_t'(op);
        sum_w   = {1'b0, acc} + {1'b0, in_value};
        diff_w  = {1'b0, acc} - {1'b0, in_value};
        add_ovf = (acc[MSB] == in_value[MSB]) && (sum_w[MSB] != acc[MSB]);
        sub_ovf = (acc[MSB] != in_value[MSB]) && (diff_w[MSB] != acc[MSB]);
        // Overflow direction always follows the sign of the old accumulator.
        sat_w   = acc[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};

        result = acc;
        carry  = 1'b0;
        ovf    = v_old;

        case (op_e)
            ACC_NOP:   result = acc;
            ACC_LOAD:  result = in_value;
            ACC_ADD: begin
                result = (SAT_EN && add_ovf) ? sat_w : sum_w[MSB:0];
                carry  = sum_w[DATA_LENGTH];
                ovf    = v_old | add_ovf;
            end
            ACC_SUB: begin
                result = (SAT_EN && sub_ovf) ? sat_w : diff_w[MSB:0];
                carry  = diff_w[DATA_LENGTH];
                ovf    = v_old | sub_ovf;
            end
            ACC_CLEAR: begin
                result = '0;
                ovf    = 1'b0;
            end
            ACC_AND:   result = acc & in_value;
            ACC_OR:    result = acc | in_value;
            ACC_XOR:   result = acc ^ in_value;
            default:   result = acc;
        endcase

        new_flags.z = (result == '0);
        new_flags.n = result[MSB];
        new_flags.c = carry;
        new_flags.v = ovf;
    end

    assign value = result;
    assign flags = new_flags;

endmodule

// File: rtl/banked_accumulator.sv
// BANKS independent accumulators sharing one ALU; one bank is read and written per cycle.
// Saturating ADD/SUB selected by defining BANKED_ACC_SATURATE_EN.
module banked_accumulator
    import acc_pkg::*;
#(
    parameter int DATA_LENGTH = 16,
    parameter int BANKS       = 4,
    parameter int BANK_SEL_W  = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [ACC_OP_W-1:0]    op,
    input  logic [BANK_SEL_W-1:0]  bank,
    input  logic [DATA_LENGTH-1:0] inValue,
    output logic [DATA_LENGTH-1:0] outValue,
    output logic                   zero,
    output logic                   negative,
    output logic                   carry,
    output logic                   overflow,
    output logic                   done
);

    logic [DATA_LENGTH-1:0] value_q [BANKS];
    logic [DATA_LENGTH-1:0] value_d [BANKS];
    acc_flags_t             flags_q [BANKS];
    acc_flags_t             flags_d [BANKS];
    logic                   done_q;
    logic                   done_d;

    logic [BANKS-1:0]       bank_hit;
    logic [DATA_LENGTH-1:0] sel_value;
    acc_flags_t             sel_flags;
    logic [DATA_LENGTH-1:0] alu_value;
    logic [3:0]             alu_flags;
    logic                   exec;

    // An out-of-range select matches no bank: reads return zero and writes drop.
    always_comb begin
        sel_value = '0;
        sel_flags = '0;
        for (int unsigned i = 0; i < BANKS; i++) begin
            bank_hit[i] = (bank == BANK_SEL_W'(i));
            if (bank_hit[i]) begin
                sel_value = value_q[i];
                sel_flags = flags_q[i];
            end
        end
    end

    assign exec = enable && (acc_op_t'(op) != ACC_NOP);

    acc_alu #(
        .DATA_LENGTH(DATA_LENGTH)
    ) u_alu (
        .acc      (sel_value),
        .in_value (inValue),
        .op       (op),
        .v_old    (sel_flags.v),
        .value    (alu_value),
        .flags    (alu_flags)
    );

    always_comb begin
        value_d = value_q;
        flags_d = flags_q;
        for (int unsigned i = 0; i < BANKS; i++) begin
            if (exec && bank_hit[i]) begin
                value_d[i] = alu_value;
                flags_d[i] = acc_flags_t'(alu_flags);
            end
        end
        done_d = exec;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < BANKS; i++) begin
                value_q[i] <= '0;
                flags_q[i] <= ACC_FLAGS_RESET;
            end
            done_q <= 1'b0;
        end else begin
            value_q <= value_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign outValue = sel_value;
    assign zero     = sel_flags.z;
    assign negative = sel_flags.n;
    assign carry    = sel_flags.c;
    assign overflow = sel_flags.v;
    assign done     = done_q;

endmodule

// File: tb/tb_banked_accumulator.sv
// Scoreboard bench for banked_accumulator: directed scenarios plus randomized ops
// checked against an arithmetic reference model of every bank.
module tb_banked_accumulator;
    import acc_pkg::*;

    localparam int DW = 16;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [2:0]    op;
    logic [1:0]    bank;
    logic [DW-1:0] inValue;
    logic [DW-1:0] outValue;
    logic          zero, negative, carry, overflow, done;

    always #5 clk = ~clk;

    banked_accumulator #(
        .DATA_LENGTH(DW),
        .BANKS(NB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .op       (op),
        .bank     (bank),
        .inValue  (inValue),
        .outValue (outValue),
        .zero     (zero),
        .negative (negative),
        .carry    (carry),
        .overflow (overflow),
        .done     (done)
    );

    typedef struct {
        logic [DW-1:0] val;
        logic          z, n, c, v, done;
    } exp_t;

    exp_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned m_val [NB];
    bit          m_z [NB], m_n [NB], m_c [NB], m_v [NB];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void model_reset();
        for (int b = 0; b < NB; b++) begin
            m_val[b] = 0; m_z[b] = 1; m_n[b] = 0; m_c[b] = 0; m_v[b] = 0;
        end
    endfunction

    function automatic int to_signed(input int unsigned u);
        return (u >= 32768) ? int'(u) - 65536 : int'(u);
    endfunction

    function automatic void model_exec(input int o, input int b, input int unsigned x);
        int unsigned a = m_val[b];
        int unsigned r = a;
        int          s = 0;
        bit          c = 0;
        bit          ovf = 0;
        case (o)
            1: r = x;
            2: begin
                r = (a + x) % 65536; c = (a + x) >= 65536;
                s = to_signed(a) + to_signed(x); ovf = (s > 32767) || (s < -32768);
            end
            3: begin
                r = (a + 65536 - x) % 65536; c = a < x;
                s = to_signed(a) - to_signed(x); ovf = (s > 32767) || (s < -32768);
            end
            4: r = 0;
            5: r = a & x;
            6: r = a | x;
            7: r = a ^ x;
            default: r = a;
        endcase
`ifdef BANKED_ACC_SATURATE_EN
        if ((o == 2 || o == 3) && ovf) r = (s > 0) ? 32'h7FFF : 32'h8000;
`endif
        m_val[b] = r;
        m_z[b]   = (r == 0);
        m_n[b]   = (r >= 32768);
        m_c[b]   = c;
        m_v[b]   = (o == 4) ? 1'b0 : (m_v[b] | ovf);
    endfunction

    task automatic issue(input bit en, input int o, input int b, input int unsigned x);
        exp_t e;
        @(negedge clk);
        enable  = en;
        op      = 3'(o);
        bank    = 2'(b);
        inValue = DW'(x);
        if (en && o != 0) model_exec(o, b, x);
        e.val  = DW'(m_val[b]);
        e.z    = m_z[b];
        e.n    = m_n[b];
        e.c    = m_c[b];
        e.v    = m_v[b];
        e.done = en && (o != 0);
        sbq.push_back(e);
    endtask

    task automatic idle_drain();
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge clk);
        #2;
        chk("sb_drain", sbq.size(), 0);
    endtask

    task automatic sweep_zero(input string tag);
        for (int k = 0; k < NB; k++) begin
            bank = 2'((k + 1) % NB);
            #1;
            chk({tag, "_val"}, outValue, 0);
            chk({tag, "_z"}, zero, 1);
            chk({tag, "_ncv"}, {negative, carry, overflow}, 0);
        end
        chk({tag, "_done"}, done, 0);
    endtask

    function automatic int unsigned pick_value();
        case ($urandom_range(0, 6))
            0:       return 32'h0000;
            1:       return 32'h0001;
            2:       return 32'h7FFF;
            3:       return 32'h8000;
            4:       return 32'hFFFF;
            default: return $urandom_range(0, 65535);
        endcase
    endfunction

    task automatic random_ops(input int n);
        for (int i = 0; i < n; i++)
            issue($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, NB - 1), pick_value());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("outValue", outValue, e.val);
                chk("flags_znc", {zero, negative, carry}, {e.z, e.n, e.c});
                chk("flag_v", overflow, e.v);
                chk("done", done, e.done);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset = 1'b0; enable = 1'b0; op = '0; bank = '0; inValue = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        sweep_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // load and isolation
        issue(1, ACC_LOAD, 1, 16'h1234);
        issue(1, ACC_ADD, 1, 16'h0001);
        issue(1, ACC_NOP, 0, 0);
        issue(1, ACC_NOP, 2, 0);
        issue(1, ACC_NOP, 3, 0);
        issue(0, ACC_NOP, 1, 0);
        // signed overflow and sticky V
        issue(1, ACC_LOAD, 2, 16'h7FFF);
        issue(1, ACC_ADD, 2, 16'h0001);
        issue(1, ACC_LOAD, 2, 16'h0005);
        // borrow then clear
        issue(1, ACC_LOAD, 3, 16'h0003);
        issue(1, ACC_SUB, 3, 16'h0005);
        issue(1, ACC_CLEAR, 3, 0);
        issue(1, ACC_CLEAR, 2, 0);
        // bitwise
        issue(1, ACC_LOAD, 0, 16'hF0F0);
        issue(1, ACC_XOR, 0, 16'hFFFF);
        issue(1, ACC_AND, 0, 16'h0000);
        issue(1, ACC_OR, 0, 16'hA5A5);
        // enable gating
        for (int i = 0; i < 5; i++) issue(0, ACC_ADD, 1, 16'h0010);

        random_ops(300);
        idle_drain();

        // asynchronous reset during an enabled ADD
        issue(1, ACC_LOAD, 1, 16'h4321);
        idle_drain();
        @(negedge clk);
        enable = 1'b1; op = 3'(ACC_ADD); bank = 2'd1; inValue = 16'h0010;
        #1;
        reset = 1'b0;
        sweep_zero("async_reset");
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        model_reset();

        random_ops(80);
        idle_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
